rc5_host_ctrl: RTL
==================

Name: rc5_host_ctrl

Overview:
- Initiator-side controller for the RC5 `algo` core. It accepts block requests on a valid/ready upstream interface and sequences the core's `encrypt`/`decrypt`/`done` handshake.
- It returns results through a registered valid/ready response port with a timeout/error flag.
- It sits between the system request fabric and `algo`, so no upstream agent drives the core directly.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles to wait for `algo_done` (RUN) or for `algo_done` to drop (DRAIN) before declaring a fault.
- MAX_ROUNDS, 31: largest legal round count; must be ≥1 and ≤31.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_op  in  1  0 = encrypt, 1 = decrypt
- in_rounds  in  5  round count, 1-indexed (1..MAX_ROUNDS legal)
- in_key  in  128  cipher key
- in_data  in  32  input block
- out_valid  out  1  response valid
- out_ready  in  1  response consumed when out_valid & out_ready
- out_data  out  32  result block (0 on error)
- out_err  out  1  1 = illegal rounds or timeout
- algo_encrypt  out  1  level strobe to core
- algo_decrypt  out  1  level strobe to core
- algo_num_rounds  out  5  to core
- algo_key  out  128  to core
- algo_d_in  out  32  to core
- algo_d_out  in  32  from core
- algo_done  in  1  from core
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE, timer=0. All of out_valid, out_data, out_err, algo_encrypt, algo_decrypt, algo_num_rounds, algo_key, algo_d_in and busy go to 0. A reset mid-operation drops the strobe immediately and discards the request.
- in_ready = (state==IDLE), combinational. No request is accepted in any other state.
- States are IDLE, RUN, RESP and DRAIN.
- IDLE, on accept at cycle N:
  - If in_rounds==0 or in_rounds>MAX_ROUNDS: go to RESP at N+1 with out_err=1 and out_data=0. No strobe is issued.
  - Otherwise: latch op, rounds, key and data into the algo_* registers. Assert exactly one of algo_encrypt (op=0) or algo_decrypt (op=1) from N+1. Clear the timer and go to RUN.
- RUN:
  - Strobe and algo_* inputs are held stable; the timer increments each cycle.
  - On the first cycle D with algo_done=1: capture algo_d_out into out_data, set out_err=0, drop the strobe at D+1, and go to RESP. out_valid=1 at D+1.
  - If the timer reaches TIMEOUT_CYCLES-1 with no done: drop the strobe, set out_data=0 and out_err=1, and go to RESP.
  - If algo_done is seen on the same cycle as the timer expiry, done wins (success).
- RESP:
  - out_valid=1; out_data and out_err are held until out_ready.
  - On handshake: out_valid=0 next cycle, clear the timer, go to DRAIN.
- DRAIN:
  - Strobes stay low.
  - Go to IDLE on the first cycle algo_done==0, so that a stale done is never attributed to the next request.
  - On timer expiry (TIMEOUT_CYCLES) go to IDLE regardless.
  - An error response that was never issued to the core (illegal rounds) still passes through DRAIN; with done low this costs 1 cycle.
- algo_encrypt and algo_decrypt are never high simultaneously; both are 0 outside RUN.
- Minimum initiator-side overhead per block is accept→strobe 1 cycle, plus done→out_valid 1 cycle, plus DRAIN ≥1 cycle.
- Timer width is $clog2(TIMEOUT_CYCLES)+1 and it saturates; it does not wrap.
- algo_d_out is sampled only on the RUN done cycle; it is ignored elsewhere.

Test Plan:
- Encrypt path: reset, then send op=0, rounds=12, key=128'h0, data=32'h0000_0000; stub core raises done 20 cycles after strobe with d_out=32'hDEAD_BEEF → algo_encrypt high for exactly 20 cycles, out_valid with out_data=32'hDEAD_BEEF and out_err=0, in_ready low until DRAIN exits.
- Decrypt path with back-pressure: op=1, rounds=31, data=32'h1234_5678, stub returns 32'hCAFE_F00D; hold out_ready=0 for 5 cycles → algo_decrypt only, out_data stable for all 5 cycles, single handshake.
- Illegal rounds: rounds=0 and, with MAX_ROUNDS=20, rounds=21 → no strobe ever asserted, out_err=1, out_data=0, next request accepted normally.
- Timeout: TIMEOUT_CYCLES=16 and stub never asserts done → strobe drops after 16 RUN cycles, out_err=1; stub that holds done high forever → DRAIN exits to IDLE after 16 cycles.
- Stale done: stub holds done for 4 cycles after strobe drop → in_ready stays low until done falls, and the next request's result comes from the next done assertion only.
- Reset mid-op: assert rst 3 cycles into RUN → all outputs 0 asynchronously, state IDLE, no out_valid after release; a following encrypt completes correctly.

Source files
------------

// File: rtl/rc5_host_ctrl.sv
// Initiator-side controller for the RC5 algo core: takes block requests over
// valid/ready, drives the core's encrypt/decrypt level strobe until done, and
// returns a registered result with an error flag for bad rounds or timeout.
module rc5_host_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_ROUNDS     = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_op,
    input  logic [4:0]   in_rounds,
    input  logic [127:0] in_key,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_err,
    output logic         algo_encrypt,
    output logic         algo_decrypt,
    output logic [4:0]   algo_num_rounds,
    output logic [127:0] algo_key,
    output logic [31:0]  algo_d_in,
    input  logic [31:0]  algo_d_out,
    input  logic         algo_done,
    output logic         busy
);

    localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX  = '1;
    localparam logic [4:0]    MAX_R  = 5'(MAX_ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;
    logic          timer_last;
    logic          rounds_bad;

    // Saturating timer step and expiry/round-legality decodes
    assign timer_inc  = (timer == T_MAX) ? timer : timer + TW'(1);
    assign timer_last = (timer == T_LAST);
    assign rounds_bad = (in_rounds == 5'd0) || (in_rounds > MAX_R);

    // Requests are only taken while idle
    assign in_ready = (state == IDLE);

    // Request sequencing, core strobe and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            timer           <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_err         <= 1'b0;
            algo_encrypt    <= 1'b0;
            algo_decrypt    <= 1'b0;
            algo_num_rounds <= '0;
            algo_key        <= '0;
            algo_d_in       <= '0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        busy <= 1'b1;
                        if (rounds_bad) begin
                            out_valid <= 1'b1;
                            out_data  <= '0;
                            out_err   <= 1'b1;
                            state     <= RESP;
                        end else begin
                            algo_num_rounds <= in_rounds;
                            algo_key        <= in_key;
                            algo_d_in       <= in_data;
                            algo_encrypt    <= ~in_op;
                            algo_decrypt    <= in_op;
                            timer           <= '0;
                            state           <= RUN;
                        end
                    end
                end
                RUN: begin
                    // done takes priority over a simultaneous timeout
                    if (algo_done) begin
                        algo_encrypt <= 1'b0;
                        algo_decrypt <= 1'b0;
                        out_valid    <= 1'b1;
                        out_data     <= algo_d_out;
                        out_err      <= 1'b0;
                        state        <= RESP;
                    end else if (timer_last) begin
                        algo_encrypt <= 1'b0;
                        algo_decrypt <= 1'b0;
                        out_valid    <= 1'b1;
                        out_data     <= '0;
                        out_err      <= 1'b1;
                        state        <= RESP;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        timer     <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // wait for a stale done to clear before the next request
                    if (!algo_done || timer_last) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
